// File: rtl/uart_fp_tx.sv
// uart_fp_tx: shifts one DATA_W-bit field element out as LSB-byte-first 8N1 frames.
// Define UART_FP_TX_HEADER_EN to prefix every word with a 0xA5 header frame.
module uart_fp_tx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 460800,
  parameter int DATA_W    = 289
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | line high, waiting for a word
  // START | start bit (tx=0) for BAUD_DIV cycles
  // DATA  | 8 data bits of the current byte, LSB first
  // STOP  | stop bit (tx=1); then next frame or back to IDLE with done

  localparam int BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int NUM_BYTES = (DATA_W + 7) / 8;
`ifdef UART_FP_TX_HEADER_EN
  localparam int NUM_FRAMES = NUM_BYTES + 1;
`else
  localparam int NUM_FRAMES = NUM_BYTES;
`endif
  localparam int SHIFT_W = NUM_FRAMES * 8;
  localparam int LOAD_W  = SHIFT_W - 8;
  localparam int BAUD_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BYTE_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [2:0]           bit_cnt;
  logic [BYTE_W-1:0]    byte_cnt;
  logic [SHIFT_W-1:0]   shift_q;
  logic [SHIFT_W-1:0]   load_word;
  logic [7:0]           cur_byte;
  logic [2:0]           bit_nxt;
  logic                 baud_end;

  // Upper pad bits of the shift register are zero-filled by the widening cast.
`ifdef UART_FP_TX_HEADER_EN
  assign load_word = {LOAD_W'(in_data), 8'hA5};
`else
  assign load_word = SHIFT_W'(in_data);
`endif

  assign cur_byte = shift_q[7:0];
  assign bit_nxt  = bit_cnt + 3'd1;
  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shift_q  <= load_word;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx       <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_nxt;
              tx      <= cur_byte[bit_nxt];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            // Returning to IDLE re-opens in_ready in the done cycle so a held
            // in_valid is taken on the very next edge.
            if (byte_cnt == BYTE_LAST) begin
              done     <= 1'b1;
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + BYTE_W'(1);
              shift_q  <= {8'h00, shift_q[SHIFT_W-1:8]};
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          tx       <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fp_tx.sv
// Bench for uart_fp_tx: a line decoder rebuilds bytes from tx and compares them
// with bytes computed from each sent word (short baud divider keeps runs small).
module tb_uart_fp_tx;
  localparam int CLK_F  = 1100;
  localparam int BAUD   = 217;
  localparam int DATA_W = 289;
  localparam int BD     = CLK_F / BAUD;
  localparam int NB     = (DATA_W + 7) / 8;
`ifdef UART_FP_TX_HEADER_EN
  localparam int NF = NB + 1;
`else
  localparam int NF = NB;
`endif
  localparam int T = NF * 10 * BD;

  typedef logic [NB*8-1:0] word_t;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, tx, busy, done;

  int n_vec = 0;
  int n_err = 0;

  uart_fp_tx #(.CLK_FREQ(CLK_F), .BAUD_RATE(BAUD), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Line monitor: one sample per cycle on the falling edge.
  int cyc = 0;
  int acc_q[$];
  int done_q[$];
  int start_q[$];
  logic [7:0] rx_q[$];
  int width_err = 0, frame_err = 0, inv_err = 0;
  bit in_frame = 0;
  int pos, k, ph;
  logic lvl;
  logic [7:0] cur;

  always @(negedge clk) begin
    cyc++;
    if ((in_ready === busy) || (done && busy)) inv_err++;
    if (done) done_q.push_back(cyc);
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    if (!rst_n) in_frame = 0;
    else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1; pos = 0; lvl = 1'b0; cur = '0;
        start_q.push_back(cyc);
      end
    end else begin
      pos++;
      k = pos / BD;
      ph = pos % BD;
      if (ph == 0) begin
        lvl = tx;
        if (k >= 1 && k <= 8) cur[k-1] = tx;
        else if (k == 9 && tx !== 1'b1) frame_err++;
      end else if (tx !== lvl) width_err++;
      if (pos == 10*BD - 1) begin
        rx_q.push_back(cur);
        in_frame = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_bytes(input word_t w, output bq_t q);
    q = {};
`ifdef UART_FP_TX_HEADER_EN
    q.push_back(8'hA5);
`endif
    for (int i = 0; i < NB; i++) q.push_back(8'(w >> (8*i)));
  endtask

  task automatic rand_word(output word_t w);
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[32*i +: 32] = $urandom;
    w = word_t'(t);
    for (int b = DATA_W; b < NB*8; b++) w[b] = 1'b0;
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int base, output int acc);
    int n = 0;
    while (acc_q.size() == base && n < 3*T) begin clk_wait(1); n++; end
    n_vec++;
    if (acc_q.size() == base) begin
      n_err++; acc = cyc;
      $display("FAIL accept_wait: got no accept want accept within %0d cycles", 3*T);
    end else acc = acc_q[base];
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_q.size() == base && n < 3*T) begin clk_wait(1); n++; end
    n_vec++;
    if (done_q.size() == base) begin
      n_err++;
      $display("FAIL done_wait: got no done want done within %0d cycles", 3*T);
    end
  endtask

  task automatic send_word(input word_t w, output int acc);
    int base = acc_q.size();
    clk_wait(1);
    in_data = w[DATA_W-1:0];
    in_valid = 1'b1;
    wait_accept(base, acc);
  endtask

  task automatic test_reset();
    int low = 0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({tx, in_ready, busy, done} !== 4'b1100) begin
      n_err++; $display("FAIL reset_hold: got %b want 1100", {tx, in_ready, busy, done});
    end
    clk_wait(0); @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({tx, in_ready, busy, done} !== 4'b1100) begin
      n_err++; $display("FAIL reset_release: got %b want 1100", {tx, in_ready, busy, done});
    end
    for (int i = 0; i < 1000; i++) begin @(negedge clk); if (tx !== 1'b1) low++; end
    n_vec++;
    if (low != 0) begin n_err++; $display("FAIL idle_tx: got %0d low cycles want 0", low); end
  endtask

  task automatic test_word(input string nm, input word_t w);
    bq_t ex;
    int acc, rxb, db, sb;
    expect_bytes(w, ex);
    rxb = rx_q.size(); db = done_q.size(); sb = start_q.size();
    send_word(w, acc);
    in_valid = 1'b0;
    wait_done(db);
    clk_wait(30);
    n_vec++;
    if (done_q.size() != db + 1) begin
      n_err++; $display("FAIL %s_done_count: got %0d want 1", nm, done_q.size() - db);
    end else begin
      n_vec++;
      if (done_q[db] - acc != T + 1) begin
        n_err++; $display("FAIL %s_latency: got %0d want %0d", nm, done_q[db] - acc - 1, T);
      end
    end
    n_vec++;
    if (start_q.size() <= sb || start_q[sb] - acc != 1) begin
      n_err++; $display("FAIL %s_start: got start missing or late want 1 cycle after accept", nm);
    end
    for (int i = 0; i < NF; i++) begin
      n_vec++;
      if (rx_q.size() <= rxb + i) begin
        n_err++; $display("FAIL %s_byte%0d: got missing want %02h", nm, i, ex[i]);
      end else if (rx_q[rxb+i] !== ex[i]) begin
        n_err++; $display("FAIL %s_byte%0d: got %02h want %02h", nm, i, rx_q[rxb+i], ex[i]);
      end
    end
    n_vec++;
    if (width_err != 0 || frame_err != 0 || inv_err != 0) begin
      n_err++;
      $display("FAIL %s_line: got width %0d stop %0d flags %0d errors want 0", nm, width_err, frame_err, inv_err);
    end
  endtask

  task automatic test_single();
    word_t w = '0;
    w[288] = 1'b1;
    w[7:0] = 8'hA5;
    test_word("single", w);
  endtask

  task automatic test_random();
    word_t w;
    for (int r = 0; r < 3; r++) begin
      rand_word(w);
      clk_wait($urandom_range(0, 20));
      test_word("random", w);
    end
  endtask

  task automatic test_handshake();
    word_t w, junk;
    bq_t ex;
    int acc, rxb, db, ab, rdy = 0;
    rand_word(w);
    expect_bytes(w, ex);
    rxb = rx_q.size(); db = done_q.size();
    send_word(w, acc);
    ab = acc_q.size();
    for (int i = 0; i < T - 10; i++) begin
      rand_word(junk);
      in_data = junk[DATA_W-1:0];
      if (in_ready !== 1'b0) rdy++;
      clk_wait(1);
    end
    in_valid = 1'b0;
    wait_done(db);
    clk_wait(5);
    n_vec++;
    if (rdy != 0 || acc_q.size() != ab) begin
      n_err++; $display("FAIL hs_ready: got %0d ready cycles, %0d extra accepts want 0", rdy, acc_q.size() - ab);
    end
    for (int i = 0; i < NF; i++) begin
      n_vec++;
      if (rx_q.size() <= rxb + i || rx_q[rxb+i] !== ex[i]) begin
        n_err++;
        $display("FAIL hs_byte%0d: got %02h want %02h", i, (rx_q.size() > rxb + i) ? rx_q[rxb+i] : 8'hxx, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    word_t w0 = word_t'(16'h0102);
    word_t w1 = word_t'(16'h0304);
    bq_t ex, ex1;
    int acc0, acc1, rxb, db, sb;
    expect_bytes(w0, ex);
    expect_bytes(w1, ex1);
    foreach (ex1[i]) ex.push_back(ex1[i]);
    rxb = rx_q.size(); db = done_q.size(); sb = start_q.size();
    send_word(w0, acc0);
    in_data = w1[DATA_W-1:0];
    wait_accept(acc_q.size(), acc1);
    in_valid = 1'b0;
    wait_done(db + 1);
    clk_wait(5);
    n_vec++;
    if (done_q.size() < db + 2 || acc1 != done_q[db]) begin
      n_err++; $display("FAIL b2b_accept: got accept at %0d want first done cycle", acc1);
    end
    n_vec++;
    if (start_q.size() <= sb + NF || done_q.size() <= db || start_q[sb+NF] - done_q[db] != 1) begin
      n_err++; $display("FAIL b2b_gap: got second start not 1 cycle after done want 1");
    end
    for (int i = 0; i < 2*NF; i++) begin
      n_vec++;
      if (rx_q.size() <= rxb + i || rx_q[rxb+i] !== ex[i]) begin
        n_err++;
        $display("FAIL b2b_byte%0d: got %02h want %02h", i, (rx_q.size() > rxb + i) ? rx_q[rxb+i] : 8'hxx, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    word_t w;
    int acc, db, sb, target;
    rand_word(w);
    w[87:72] = '0;
    db = done_q.size();
    send_word(w, acc);
    in_valid = 1'b0;
    target = acc + 1 + 10*10*BD + 4*BD + 1;
    while (cyc < target) clk_wait(1);
    n_vec++;
    if (tx !== 1'b0) begin n_err++; $display("FAIL mid_pre: got tx=%b want 0", tx); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL mid_async_tx: got tx=%b want 1", tx); end
    clk_wait(3);
    rst_n = 1'b1;
    sb = start_q.size();
    clk_wait(T + 50);
    n_vec++;
    if (done_q.size() != db || start_q.size() != sb) begin
      n_err++; $display("FAIL mid_quiet: got %0d done %0d starts want 0 0", done_q.size() - db, start_q.size() - sb);
    end
    rand_word(w);
    test_word("after_reset", w);
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
